// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared types and helpers for the exhaustive sweep capture engine.
//   mode_e      : vector ordering selected at start
//   state_e     : sweep FSM states
//   LFSR_TAPS   : maximal-length Fibonacci tap masks, indexed by width 2..16
//   next_vector : successor vector for a given ordering
// -----------------------------------------------------------------------------
package sweep_pkg;

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_LOG    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Tap masks for a left-shifting Fibonacci LFSR whose feedback bit is the
  // XOR of the masked state, inserted at bit 0. Entries 0 and 1 are unused.
  localparam logic [15:0] LFSR_TAPS [0:16] = '{
    16'h0000, 16'h0000, 16'h0003, 16'h0006, 16'h000C, 16'h0014,
    16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240, 16'h0500,
    16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
  };

  // Vector for sweep index idx. For LFSR ordering the result is derived from
  // the current vector lfsr instead: 0 is followed by the seed 1, and every
  // nonzero state steps the register once.
  function automatic logic [15:0] next_vector(
    input mode_e       mode,
    input logic [15:0] idx,
    input logic [15:0] lfsr,
    input logic [4:0]  width
  );
    logic [15:0] mask;
    logic [15:0] res;
    logic        fb;
    mask = 16'hFFFF >> (5'd16 - width);
    fb   = ^(lfsr & LFSR_TAPS[width]);
    case (mode)
      MODE_GRAY: res = idx ^ (idx >> 1);
      MODE_LFSR: begin
        if (lfsr == 16'h0000) begin
          res = 16'h0001;
        end else begin
          res = {lfsr[14:0], fb};
        end
      end
      default:   res = idx;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// -----------------------------------------------------------------------------
// sweep_misr
// Multiple-input signature register folding each sampled response into sig.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (start of a sweep), wins over en
//   en         : fold resp into the signature this cycle
//   resp       : N_OUT-bit response, zero-extended to SIG_W
//   sig        : current signature
// -----------------------------------------------------------------------------
module sweep_misr
  import sweep_pkg::*;
#(
  parameter int unsigned SIG_W    = 16,
  parameter logic [31:0] SIG_POLY = 32'h0000_1021,
  parameter int unsigned N_OUT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [N_OUT-1:0] resp,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] POLY = SIG_POLY[SIG_W-1:0];

  logic [SIG_W-1:0] sig_r;
  logic [SIG_W-1:0] resp_ext_s;
  logic [SIG_W-1:0] fb_s;

  // Zero-extend the response and select the feedback term from the MSB.
  always_comb begin
    resp_ext_s = '0;
    resp_ext_s[N_OUT-1:0] = resp;
    if (sig_r[SIG_W-1]) begin
      fb_s = POLY;
    end else begin
      fb_s = '0;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= '0;
    end else if (clr) begin
      sig_r <= '0;
    end else if (en) begin
      sig_r <= (sig_r << 1) ^ fb_s ^ resp_ext_s;
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/sweep_capture_engine.sv
// -----------------------------------------------------------------------------
// sweep_capture_engine
// Drives every 2^N_IN stimulus vector into a device under test, samples its
// response after SETTLE cycles, streams (stim, resp) records over a
// valid/ready log port and compresses all responses into a MISR signature.
//
// Ports
//   CK, reset         : clock (rising edge), asynchronous active-low reset
//   start, abort      : begin a sweep when idle / end a sweep early
//   mode              : 0 binary, 1 Gray, 2 LFSR, 3 binary; latched at start
//   stim, resp        : vector to the DUT / its response
//   log_valid/ready   : record handshake; log_stim/log_resp hold the record
//   busy, done        : sweep in progress / one-cycle end-of-sweep pulse
//   aborted           : last sweep ended by abort (sticky until next start)
//   vec_count         : records accepted in the current or last sweep
//   sig               : MISR signature
//
// Build option SWEEP_FIRST_HIT_EN adds hit_seen/hit_stim, which capture the
// stimulus of the first sampled response with any bit set.
// -----------------------------------------------------------------------------
module sweep_capture_engine
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN     = 8,
  parameter int unsigned N_OUT    = 1,
  parameter int unsigned SETTLE   = 1,
  parameter int unsigned SIG_W    = 16,
  parameter logic [31:0] SIG_POLY = 32'h0000_1021
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] resp,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [N_IN-1:0]  log_stim,
  output logic [N_OUT-1:0] log_resp,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [N_IN:0]    vec_count,
  output logic [SIG_W-1:0] sig
`ifdef SWEEP_FIRST_HIT_EN
  ,
  output logic             hit_seen,
  output logic [N_IN-1:0]  hit_stim
`endif
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN:0]    SWEEP_LEN   = {1'b1, {N_IN{1'b0}}};

  state_e             state_r;
  mode_e              mode_r;
  logic [CNT_W-1:0]   settle_cnt_r;
  logic [N_IN-1:0]    stim_r;
  logic               log_valid_r;
  logic [N_IN-1:0]    log_stim_r;
  logic [N_OUT-1:0]   log_resp_r;
  logic               busy_r;
  logic               done_r;
  logic               aborted_r;
  logic [N_IN:0]      vec_count_r;
`ifdef SWEEP_FIRST_HIT_EN
  logic               hit_seen_r;
  logic [N_IN-1:0]    hit_stim_r;
`endif

  logic [N_IN:0]      next_idx_s;
  logic [N_IN-1:0]    next_stim_s;
  logic               last_s;
  logic               misr_clr_s;
  logic               misr_en_s;

  // Successor vector, last-vector detect and MISR control.
  always_comb begin
    next_idx_s  = vec_count_r + 1'b1;
    last_s      = (next_idx_s == SWEEP_LEN);
    next_stim_s = N_IN'(next_vector(mode_r, 16'(next_idx_s), 16'(stim_r), 5'(N_IN)));
    if ((state_r == ST_IDLE) && start) begin
      misr_clr_s = 1'b1;
    end else begin
      misr_clr_s = 1'b0;
    end
    // An abort during SAMPLE cancels the capture, including the MISR fold.
    if ((state_r == ST_SAMPLE) && !abort) begin
      misr_en_s = 1'b1;
    end else begin
      misr_en_s = 1'b0;
    end
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      mode_r       <= MODE_BIN;
      settle_cnt_r <= '0;
      stim_r       <= '0;
      log_valid_r  <= 1'b0;
      log_stim_r   <= '0;
      log_resp_r   <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      vec_count_r  <= '0;
`ifdef SWEEP_FIRST_HIT_EN
      hit_seen_r   <= 1'b0;
      hit_stim_r   <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_DRIVE;
            mode_r       <= mode_e'(mode);
            settle_cnt_r <= '0;
            stim_r       <= '0;
            busy_r       <= 1'b1;
            aborted_r    <= 1'b0;
            vec_count_r  <= '0;
`ifdef SWEEP_FIRST_HIT_EN
            hit_seen_r   <= 1'b0;
            hit_stim_r   <= '0;
`endif
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            aborted_r <= 1'b1;
          end else if (settle_cnt_r == SETTLE_LAST) begin
            state_r <= ST_SAMPLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            aborted_r <= 1'b1;
          end else begin
            state_r     <= ST_LOG;
            log_stim_r  <= stim_r;
            log_resp_r  <= resp;
            log_valid_r <= 1'b1;
`ifdef SWEEP_FIRST_HIT_EN
            if (!hit_seen_r && (|resp)) begin
              hit_seen_r <= 1'b1;
              hit_stim_r <= stim_r;
            end
`endif
          end
        end
        ST_LOG: begin
          if (log_ready) begin
            // Handshake completes even when abort arrives in the same cycle.
            log_valid_r <= 1'b0;
            vec_count_r <= next_idx_s;
            if (last_s || abort) begin
              state_r   <= ST_DONE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              aborted_r <= abort && !last_s;
            end else begin
              state_r      <= ST_DRIVE;
              stim_r       <= next_stim_s;
              settle_cnt_r <= '0;
            end
          end else if (abort) begin
            // Pending record is dropped.
            log_valid_r <= 1'b0;
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            aborted_r   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          log_valid_r <= 1'b0;
        end
      endcase
    end
  end

  sweep_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY),
    .N_OUT    (N_OUT)
  ) u_misr (
    .clk   (CK),
    .rst_n (reset),
    .clr   (misr_clr_s),
    .en    (misr_en_s),
    .resp  (resp),
    .sig   (sig)
  );

  assign stim      = stim_r;
  assign log_valid = log_valid_r;
  assign log_stim  = log_stim_r;
  assign log_resp  = log_resp_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign aborted   = aborted_r;
  assign vec_count = vec_count_r;
`ifdef SWEEP_FIRST_HIT_EN
  assign hit_seen  = hit_seen_r;
  assign hit_stim  = hit_stim_r;
`endif

endmodule

// File: tb/tb_sweep_capture_engine.sv
// -----------------------------------------------------------------------------
// tb_sweep_capture_engine
// Scoreboard bench: each sweep pushes its expected records and end-of-sweep
// summary; a monitor on the falling edge pops and compares them whenever the
// engine presents a record handshake or a done pulse.
// -----------------------------------------------------------------------------
module tb_sweep_capture_engine;

  localparam int N_IN   = 3;
  localparam int N_OUT  = 2;
  localparam int SETTLE = 2;
  localparam int SIG_W  = 4;
  localparam int CW     = N_IN + 1;
  localparam int NVEC   = 8;
  localparam logic [31:0] SIG_POLY = 32'h0000_0003;

  logic             CK = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [N_IN-1:0]  stim;
  logic [N_OUT-1:0] resp;
  logic             log_valid;
  logic             log_ready = 1'b0;
  logic [N_IN-1:0]  log_stim;
  logic [N_OUT-1:0] log_resp;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [N_IN:0]    vec_count;
  logic [SIG_W-1:0] sig;

  // Behavioural device under test: a per-sweep lookup table.
  logic [N_OUT-1:0] resp_tbl [NVEC];
  assign resp = resp_tbl[stim];

  typedef struct packed { logic [N_IN-1:0] s; logic [N_OUT-1:0] r; } rec_t;
  typedef struct packed { logic [N_IN:0] cnt; logic ab; logic [SIG_W-1:0] sig; } sum_t;

  rec_t rec_q[$];
  sum_t sum_q[$];
  int   lfsr_seq [NVEC];
  int   ready_mode = 0;   // 0 random, 1 held low, 2 held high
  int   vectors = 0;
  int   miscompares = 0;

  sweep_capture_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE), .SIG_W(SIG_W), .SIG_POLY(SIG_POLY)
  ) dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .stim(stim), .resp(resp), .log_valid(log_valid), .log_ready(log_ready),
    .log_stim(log_stim), .log_resp(log_resp), .busy(busy), .done(done),
    .aborted(aborted), .vec_count(vec_count), .sig(sig)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // i-th vector of a sweep in the given ordering.
  function automatic int order_vec(input int m, input int i);
    if (m == 1) return i ^ (i >> 1);
    else if (m == 2) return lfsr_seq[i];
    else return i;
  endfunction

  // Signature as polynomial arithmetic: s*x mod (x^4 + x + 1) plus response.
  function automatic int model_sig(input int m, input int nsamp);
    int s;
    s = 0;
    for (int i = 0; i < nsamp; i++) begin
      s = ((s * 2) % 16) ^ ((s / 8) * 3) ^ int'(resp_tbl[order_vec(m, i)]);
    end
    return s;
  endfunction

  // log_ready driver.
  initial begin
    forever begin
      @(posedge CK);
      #1;
      case (ready_mode)
        1:       log_ready = 1'b0;
        2:       log_ready = 1'b1;
        default: log_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: record handshakes, stall stability and done summaries.
  logic            pend_v = 1'b0;
  logic [N_IN-1:0] pend_ls, pend_st;
  logic [N_OUT-1:0] pend_lr;
  int              rec_idx = 0;
  rec_t            mrec;
  sum_t            msum;
  always @(negedge CK) begin
    if (!reset) begin
      pend_v  = 1'b0;
      rec_idx = 0;
    end else begin
      if (pend_v) begin
        check("stall_valid", log_valid, 1);
        check("stall_log_stim", log_stim, pend_ls);
        check("stall_log_resp", log_resp, pend_lr);
        check("stall_stim", stim, pend_st);
      end
      pend_v = log_valid && !log_ready && !abort;
      pend_ls = log_stim; pend_lr = log_resp; pend_st = stim;
      if (log_valid && log_ready) begin
        if (rec_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_record: got stim %0h, none expected", log_stim);
        end else begin
          mrec = rec_q.pop_front();
          check("log_stim", log_stim, mrec.s);
          check("log_resp", log_resp, mrec.r);
          check("vec_count_at_hs", vec_count, rec_idx);
          rec_idx++;
        end
      end
      if (done) begin
        rec_idx = 0;
        if (sum_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: got done, none expected");
        end else begin
          msum = sum_q.pop_front();
          check("done_vec_count", vec_count, msum.cnt);
          check("done_aborted", aborted, msum.ab);
          check("done_sig", sig, msum.sig);
          check("done_busy", busy, 0);
        end
      end
    end
  end

  // kind: 0 normal, 1 abort in DRIVE of k, 2 abort in LOG of k without
  // handshake, 3 abort with handshake on k, 4 reset at k, 5 five-cycle stall
  // on k, 6 start with abort, 7 extra start while busy at k.
  task automatic run_sweep(input int m, input int kind, input int k, input int tbl_kind);
    int   nacc, nsamp, v, tgt;
    logic ab;
    bit   seen;
    rec_t rc;
    sum_t sm;
    for (int i = 0; i < NVEC; i++) begin
      case (tbl_kind)
        0:       resp_tbl[i] = '0;
        1:       resp_tbl[i] = 2'b01;
        default: resp_tbl[i] = N_OUT'($urandom);
      endcase
    end
    nacc = NVEC; nsamp = NVEC; ab = 1'b0;
    case (kind)
      1: begin nacc = k;     nsamp = k;     ab = 1'b1; end
      2: begin nacc = k;     nsamp = k + 1; ab = 1'b1; end
      3: begin nacc = k + 1; nsamp = k + 1; ab = 1'b1; end
      4: begin nacc = k;     nsamp = k;     end
      default: ;
    endcase
    for (int i = 0; i < nacc; i++) begin
      v = order_vec(m, i);
      rc.s = N_IN'(v); rc.r = resp_tbl[v];
      rec_q.push_back(rc);
    end
    if (kind != 4) begin
      sm.cnt = CW'(nacc); sm.ab = ab; sm.sig = SIG_W'(model_sig(m, nsamp));
      sum_q.push_back(sm);
    end
    ready_mode = (kind == 0 || kind == 6 || kind == 7) ? 0 : 2;
    tgt = order_vec(m, k);

    @(posedge CK); #1;
    start = 1'b1; mode = m[1:0];
    if (kind == 6) abort = 1'b1;
    @(posedge CK); #1;
    start = 1'b0; abort = 1'b0;

    if (kind >= 1 && kind != 6) begin
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
        @(negedge CK);
        if (busy && stim == N_IN'(tgt)) seen = 1'b1;
      end
      check("reach_vector", seen, 1);
      if (kind == 1 || kind == 7) begin
        @(posedge CK); #1;
        if (kind == 1) abort = 1'b1; else start = 1'b1;
        @(posedge CK); #1;
        abort = 1'b0; start = 1'b0;
      end else if (kind == 4) begin
        #2 reset = 1'b0;
        #1 check("reset_mid_outputs",
                 {stim, log_valid, log_stim, log_resp, busy, done, aborted, vec_count, sig}, 0);
        rec_q.delete(); sum_q.delete();
        repeat (2) @(posedge CK);
        #1 reset = 1'b1;
        return;
      end else begin
        ready_mode = 1;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
          @(negedge CK);
          if (log_valid) seen = 1'b1;
        end
        check("reach_log", seen, 1);
        if (kind == 5) begin
          for (int c = 0; c < 5; c++) begin
            @(negedge CK);
            check("stall_vec_count", vec_count, k);
            check("stall_pending_stim", log_stim, tgt);
          end
          ready_mode = 2;
        end else begin
          if (kind == 3) ready_mode = 2;
          @(posedge CK); #1 abort = 1'b1;
          @(posedge CK); #1 abort = 1'b0;
        end
      end
    end

    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge CK);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    @(posedge CK); #1;
    check("idle_aborted", aborted, ab);
    check("idle_vec_count", vec_count, nacc);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    lfsr_seq = '{0, 1, 2, 5, 3, 7, 6, 4};   // 0, then x^3+x^2+1 from seed 1
    for (int i = 0; i < NVEC; i++) resp_tbl[i] = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge CK);
    #1 check("reset_outputs",
             {stim, log_valid, log_stim, log_resp, busy, done, aborted, vec_count, sig}, 0);
    reset = 1'b1;
    repeat (2) @(posedge CK);

    run_sweep(0, 0, 0, 0);   // binary, zero responses
    run_sweep(1, 0, 0, 2);   // Gray
    run_sweep(2, 0, 0, 2);   // LFSR
    run_sweep(3, 0, 0, 2);   // reserved -> binary
    run_sweep(0, 0, 0, 1);   // constant response 1
    run_sweep(0, 5, 2, 2);   // stall on record 2
    run_sweep(0, 1, 5, 2);   // abort in DRIVE of vector 5
    run_sweep(1, 2, 3, 2);   // abort in LOG, record dropped
    run_sweep(2, 3, 6, 2);   // abort together with handshake
    run_sweep(0, 4, 4, 2);   // reset mid-sweep
    run_sweep(0, 0, 0, 2);   // restart after reset
    run_sweep(1, 6, 0, 2);   // start and abort together
    run_sweep(2, 7, 3, 2);   // start while busy

    // Abort while idle must not produce a done pulse or change aborted.
    @(posedge CK); #1 abort = 1'b1;
    @(posedge CK); #1 abort = 1'b0;
    repeat (3) @(posedge CK);
    #1 check("idle_abort_busy", busy, 0);
    check("idle_abort_aborted", aborted, 0);

    for (int n = 0; n < 6; n++) run_sweep(int'($urandom_range(0, 3)), 0, 0, 2);

    repeat (5) @(posedge CK);
    check("rec_queue_empty", rec_q.size(), 0);
    check("sum_queue_empty", sum_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sweep_capture_engine.md
Name: sweep_capture_engine

Overview:
- Synthesizable successor to the fixed 8-input exhaustive sweep bench: drives every 2^N_IN input vector into a DUT under test, samples an N_OUT-bit response and streams (stimulus, response) records out over a valid/ready log port.
- Compresses all responses into a MISR signature so the on-chip result can be compared against a golden value.
- Sits between the trojan-detection harness controller and the design under test. Supports binary, Gray and LFSR vector orderings.

Parameters:
- N_IN, 8, stimulus width (2..16); sweep length is 2^N_IN vectors
- N_OUT, 1, response width (1..SIG_W)
- SETTLE, 1, cycles stim is held before response is sampled (>=1)
- SIG_W, 16, MISR width
- SIG_POLY, 16'h1021, MISR feedback polynomial (low SIG_W bits used)

Ports:
- CK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a sweep when idle
- abort  in  1  pulse; ends the sweep early
- mode  in  2  0=binary ascending, 1=Gray, 2=LFSR, 3=reserved (treated as binary); sampled at start
- stim  out  N_IN  vector driven to the DUT
- resp  in  N_OUT  DUT response
- log_valid  out  1  record available
- log_ready  in  1  consumer accepts record
- log_stim  out  N_IN  stimulus of the record
- log_resp  out  N_OUT  response of the record
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep (normal or aborted)
- aborted  out  1  last sweep ended by abort; sticky until next start
- vec_count  out  N_IN+1  records accepted in the current or last sweep
- sig  out  SIG_W  MISR signature

Behaviour:
- Reset is asynchronous, active-low. On assertion every output is 0 and the FSM goes to IDLE.
- FSM states: IDLE, DRIVE, SAMPLE, LOG, DONE.
- IDLE: when start=1, the next cycle enters DRIVE with busy=1 and stim=first vector (always 0). On the same edge sig, vec_count and aborted clear and mode is latched. start is ignored while busy.
- DRIVE: stim is held for SETTLE cycles, then the FSM moves to SAMPLE.
- SAMPLE: one cycle. Captures log_stim<=stim and log_resp<=resp, updates the MISR, then moves to LOG with log_valid=1.
- MISR update: sig <= (sig<<1) ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zero-extended resp.
- LOG: log_valid, log_stim and log_resp stay stable until log_valid&&log_ready. On that handshake vec_count increments.
  - If this was the last vector (vec_count reaches 2^N_IN), go to DONE.
  - Otherwise stim advances to the next vector and the FSM goes to DRIVE.
  - stim never changes while a record is pending.
- Vector orderings:
  - Binary: index i.
  - Gray: i ^ (i>>1).
  - LFSR: 0 first, then a Fibonacci LFSR seeded with 1 that steps through all 2^N_IN-1 nonzero states.
- DONE: one cycle. done=1 and busy=0, then IDLE. stim keeps its last value. sig and vec_count hold until the next start.
- Abort:
  - In DRIVE or SAMPLE, abort is honoured immediately; the in-progress vector is not logged.
  - In LOG, a handshake in the same cycle completes first, then the FSM goes to DONE; without the handshake the pending record is dropped.
  - aborted=1 at the done pulse.
  - abort while idle is ignored.
- start and abort in the same idle cycle: start wins and abort is ignored.
- Width rule: vec_count is N_IN+1 bits so 2^N_IN is representable without wrap.

Optional Feature:
- SWEEP_FIRST_HIT_EN, when defined:
  - Adds outputs hit_seen (1) and hit_stim (N_IN), both cleared at start.
  - Latches stim of the first sampled response with any bit set; hit_seen is sticky. This flags rare trigger conditions.
- When undefined: the ports are absent and there is no added logic.

Decomposition:
- Package sweep_pkg holds:
  - mode_e enum
  - state_e enum
  - LFSR tap-mask constant table indexed by width 2..16
  - function next_vector(mode, idx, lfsr)
- One sub-module, sweep_misr: parametrised SIG_W/SIG_POLY/N_OUT, with clear and enable inputs and a sig output.

Test Plan:
- N_IN=3, mode=0, log_ready=1, resp=0 -> log_stim 0..7 in order, done after 8 records, vec_count=8, sig=0.
- N_IN=3, mode=1 -> log_stim sequence 0,1,3,2,6,7,5,4.
- N_IN=2, SIG_W=4, SIG_POLY=4'h3, resp held 1 -> sig=4'hF after 4 records.
- log_ready low for 5 cycles on record 2 -> log_valid and log_stim stable at 2, stim unchanged, vec_count=2 until release.
- abort in DRIVE of vector 5 (N_IN=3) -> done pulse, aborted=1, vec_count=5, no record for 5.
- reset deasserted then asserted mid-sweep at vector 4 -> all outputs 0 immediately, IDLE; a new start restarts at vector 0.
